char_stream_ctrl: RTL and testbench

//  Sequences the character ROM: queues 6-bit character codes, walks rows 0..7 of each

---
 rtl/char_pkg.sv | 14 +
 rtl/char_fifo.sv | 54 +++++
 rtl/char_stream_ctrl.sv | 118 +++++++++++
 tb/tb_char_stream_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared types and default widths for the character stream controller.
package char_pkg;

  localparam int unsigned CHAR_W_D      = 6;
  localparam int unsigned ROW_W_D       = 3;
  localparam int unsigned DATA_W_D      = 8;
  localparam int unsigned ROWS_PER_CHAR = 2 ** ROW_W_D;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/char_fifo.sv
// Character code FIFO: no bypass, push ignored when full, pop ignored when empty.
module char_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CHAR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [CHAR_W-1:0] push_data,
  input  logic              pop,
  output logic [CHAR_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CHAR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign pop_data  = r_mem[r_rd];

  // Storage array, written on accepted push only.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= push_data;
  end

  // Pointers and occupancy; rst and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/char_stream_ctrl.sv
// Queues character codes and streams their ROM rows out on a valid/ready port.
module char_stream_ctrl
  import char_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CHAR_W = CHAR_W_D,
  parameter int unsigned ROW_W  = ROW_W_D,
  parameter int unsigned DATA_W = DATA_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [CHAR_W-1:0] in_char,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CHAR_W-1:0] rom_char,
  output logic [ROW_W-1:0]  rom_row,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [ROW_W-1:0] LAST_ROW = '1;

  state_t              r_state;
  logic [ROW_W-1:0]    r_row;
  logic [CHAR_W-1:0]   r_cur_char;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_first;
  logic                r_out_last;
  logic                r_out_valid;

  logic                w_full;
  logic                w_empty;
  logic [CHAR_W-1:0]   w_fifo_data;
  logic                w_push;
  logic                w_load;
  logic                w_pop;

  assign in_ready = ~rst & ~flush & ~w_full;
  assign w_push   = in_valid & in_ready;
  assign w_load   = (r_state == EMIT) & (~r_out_valid | out_ready);
  // Pop when idle with work queued, or when the last row loads and another char waits.
  assign w_pop    = ~w_empty & ((r_state == IDLE) | (w_load & (r_row == LAST_ROW)));

  assign rom_char  = (r_state == EMIT) ? r_cur_char : '0;
  assign rom_row   = (r_state == EMIT) ? r_row : '0;
  assign out_data  = r_out_data;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != IDLE) | ~w_empty | r_out_valid;

  char_fifo #(
    .DEPTH (DEPTH),
    .CHAR_W(CHAR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (w_push),
    .push_data(in_char),
    .pop      (w_pop),
    .pop_data (w_fifo_data),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Readout FSM, row counter and registered output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_cur_char  <= '0;
      r_out_data  <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= rom_data;
        r_out_valid <= 1'b1;
        r_out_first <= (r_row == '0);
        r_out_last  <= (r_row == LAST_ROW);
        // Row wraps to 0 naturally on the last row, ready for the next char.
        r_row       <= r_row + 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_cur_char <= w_fifo_data;
            r_row      <= '0;
            r_state    <= EMIT;
          end
        end
        EMIT: begin
          if (w_load && (r_row == LAST_ROW)) begin
            if (w_pop) r_cur_char <= w_fifo_data;
            else       r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_stream_ctrl.sv
// Directed bench for char_stream_ctrl with a combinational ROM model.
module tb_char_stream_ctrl;
  import char_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [5:0] in_char;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] rom_char;
  logic [2:0] rom_row;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_first;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [5:0] c, input logic [2:0] r);
    return {c, 2'b00} ^ (8'({5'b0, r}) * 8'd41);
  endfunction

  assign rom_data = rom_f(rom_char, rom_row);

  char_stream_ctrl #(
    .DEPTH (8),
    .CHAR_W(6),
    .ROW_W (3),
    .DATA_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_char  (in_char),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rom_char (rom_char),
    .rom_row  (rom_row),
    .rom_data (rom_data),
    .out_data (out_data),
    .out_first(out_first),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consume rows of every char in q; strict forbids bubbles once streaming starts.
  task automatic stream(input bit strict, input bit rnd);
    int idx = 0;
    int cyc = 0;
    int total;
    bit started = 0;
    logic rdy;
    logic [5:0] c;
    logic [2:0] r;
    total = q.size() * ROWS_PER_CHAR;
    while (idx < total && cyc < 2000) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid) begin
        started = 1;
        c = 6'(q[idx / 8]);
        r = 3'(idx % 8);
        chk("out_data", 32'(out_data), 32'(rom_f(c, r)));
        chk("out_first", 32'(out_first), 32'(r == 3'd0));
        chk("out_last", 32'(out_last), 32'(r == 3'd7));
        if (r != 3'd7) begin
          chk("rom_char", 32'(rom_char), 32'(c));
          chk("rom_row", 32'(rom_row), 32'(r + 3'd1));
        end else if (idx / 8 + 1 < q.size()) begin
          chk("rom_char_next", 32'(rom_char), 32'(q[idx / 8 + 1]));
          chk("rom_row_next", 32'(rom_row), 32'd0);
        end
        if (rdy) idx++;
      end else if (started && strict) begin
        chk("bubble", 32'(out_valid), 32'd1);
      end
      step();
      cyc++;
    end
    chk("stream_complete", 32'(idx), 32'(total));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_char = '0; in_valid = 1'b0; out_ready = 1'b0;

    // 1 reset
    in_valid = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst_in_ready2", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_first_last", 32'({out_first, out_last}), 32'd0);
    chk("rst_rom", 32'({rom_char, rom_row}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    step();

    // 2 single char with latency
    out_ready = 1'b1;
    in_char = 6'h21; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_n", 32'(out_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    step();
    chk("lat_n1", 32'(out_valid), 32'd0);
    chk("lat_rom_char", 32'(rom_char), 32'h21);
    step();
    chk("lat_n2", 32'(out_valid), 32'd1);
    q = '{32'h21};
    stream(1'b1, 1'b0);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_out_valid", 32'(out_valid), 32'd0);

    // 3 back-to-back chars
    q = '{32'h01, 32'h02, 32'h03};
    for (int unsigned k = 0; k < 3; k++) begin
      in_char = 6'(q[k]); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    stream(1'b1, 1'b0);
    chk("b2b_busy", 32'(busy), 32'd0);

    // 4 random backpressure
    out_ready = 1'b0;
    q = '{32'h3F, 32'h15};
    for (int unsigned k = 0; k < 2; k++) begin
      in_char = 6'(q[k]); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    stream(1'b0, 1'b1);
    out_ready = 1'b1;
    step();
    chk("bp_busy", 32'(busy), 32'd0);

    // 5 fill the queue while stalled
    out_ready = 1'b0;
    q.delete();
    for (int unsigned k = 0; k < 10; k++) begin
      in_char = 6'(6'h30 + k); in_valid = 1'b1;
      #1;
      if (in_ready) q.push_back(32'(6'h30 + k));
      step();
    end
    in_valid = 1'b0;
    chk("full_accepts", 32'(q.size()), 32'd9);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_last_accepted", 32'(q[q.size() - 1]), 32'h38);
    stream(1'b1, 1'b0);
    chk("full_drain_busy", 32'(busy), 32'd0);

    // 6 flush mid-character
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      in_char = 6'(6'h10 + k); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("pre_flush_row3", 32'(out_data), 32'(rom_f(6'h10, 3'd3)));
    chk("pre_flush_first", 32'(out_first), 32'd0);
    flush = 1'b1; in_char = 6'h2A; in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_rom", 32'({rom_char, rom_row}), 32'd0);
    step(); step(); step();
    chk("flush_stays_idle", 32'({out_valid, busy}), 32'd0);
    q = '{32'h05};
    in_char = 6'h05; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    stream(1'b1, 1'b0);
    chk("restart_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
